aes_round_ctrl: RTL and testbench

// Sequencing FSM for the AES-128 encryption datapath. Accepts one block per
// in_valid/in_ready handshake and drives the step enables for the shared state

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_step_timer.sv | 28 ++
 rtl/aes_round_ctrl.sv | 131 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round controller.
// Round-counter and step-timer widths live here so the sub-module and top agree.
package aes_pkg;

    localparam int unsigned Aes128Rounds = 10;
    localparam int unsigned RoundW       = 4;
    localparam int unsigned TimerW       = 3;

    typedef enum logic [2:0] {
        StIdle,
        StInitArk,
        StSub,
        StShift,
        StMix,
        StArk,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/aes_step_timer.sv
// Loadable 3-bit down-counter with a zero flag.
// Sets how many cycles a multi-cycle datapath step is held enabled.
module aes_step_timer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TimerW-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [TimerW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - TimerW'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing FSM for the AES-128 encryption datapath: one block per handshake,
// Moore-decoded step enables and a held ciphertext-valid until the consumer takes it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = Aes128Rounds,
    parameter int unsigned MC_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              state_load,
    output logic              sb_en,
    output logic              sr_en,
    output logic              mc_en,
    output logic              ark_en,
    output logic              key_step,
    output logic [RoundW-1:0] round,
    output logic              busy
);

    localparam logic [RoundW-1:0] LastRound = RoundW'(NUM_ROUNDS);
    localparam logic [TimerW-1:0] McLoad    = TimerW'(MC_LAT - 1);

    ctrl_state_e       state_q, state_d;
    logic [RoundW-1:0] round_q, round_d;
    logic              in_ready_q;
    logic              tmr_load, tmr_dec, tmr_zero;

    // Reset gates in_ready directly so it drops the moment rst goes low.
    assign in_ready   = in_ready_q & rst;
    assign state_load = in_valid & in_ready;
    assign round      = round_q;

    aes_step_timer u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (McLoad),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (state_load) begin
                    state_d = StInitArk;
                    round_d = '0;
                end
            end
            StInitArk: begin
                round_d = RoundW'(1);
                state_d = StSub;
            end
            StSub: begin
                state_d = StShift;
            end
            StShift: begin
                if (round_q < LastRound) begin
                    state_d  = StMix;
                    tmr_load = 1'b1;
                end else begin
                    state_d = StArk;
                end
            end
            StMix: begin
                if (tmr_zero) begin
                    state_d = StArk;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StArk: begin
                if (round_q == LastRound) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + RoundW'(1);
                    state_d = StSub;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            round_q    <= '0;
            in_ready_q <= 1'b1;
            out_valid  <= 1'b0;
            sb_en      <= 1'b0;
            sr_en      <= 1'b0;
            mc_en      <= 1'b0;
            ark_en     <= 1'b0;
            key_step   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            in_ready_q <= (state_d == StIdle);
            out_valid  <= (state_d == StDone);
            sb_en      <= (state_d == StSub);
            sr_en      <= (state_d == StShift);
            mc_en      <= (state_d == StMix);
            ark_en     <= (state_d == StInitArk) || (state_d == StArk);
            key_step   <= (state_d == StShift);
            busy       <= (state_d != StIdle) && (state_d != StDone);
        end
    end

    ark_round_legal: assert property (
        @(posedge clk) disable iff (!rst) (state_q == StArk) |-> (round_q <= LastRound)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one instance with MC_LAT=1 (default),
// a second with MC_LAT=3, sharing clock and reset.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_state_load;
    logic       a_sb, a_sr, a_mc, a_ark, a_key, a_busy;
    logic [3:0] a_round;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_state_load;
    logic       b_sb, b_sr, b_mc, b_ark, b_key, b_busy;
    logic [3:0] b_round;

    int checks = 0;
    int passed = 0;

    aes_round_ctrl u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .state_load (a_state_load),
        .sb_en      (a_sb),
        .sr_en      (a_sr),
        .mc_en      (a_mc),
        .ark_en     (a_ark),
        .key_step   (a_key),
        .round      (a_round),
        .busy       (a_busy)
    );

    aes_round_ctrl #(.NUM_ROUNDS(10), .MC_LAT(3)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .state_load (b_state_load),
        .sb_en      (b_sb),
        .sr_en      (b_sr),
        .mc_en      (b_mc),
        .ark_en     (b_ark),
        .key_step   (b_key),
        .round      (b_round),
        .busy       (b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one block through DUT A from idle to DONE and reports what it saw.
    task automatic run_a(output int sl0, output int lat, output int sb, output int sr,
                         output int mc, output int ark, output int key, output int bsy,
                         output int extra, output int rdy);
        sb = 0; sr = 0; mc = 0; ark = 0; key = 0; bsy = 0; extra = 0; rdy = 0; lat = 0;
        a_in_valid = 1'b1;
        #1;
        sl0 = int'(a_state_load);
        step();
        while (!a_out_valid && lat < 200) begin
            a_in_valid = (lat >= 5 && lat <= 8);
            #1;
            sb    += int'(a_sb);
            sr    += int'(a_sr);
            mc    += int'(a_mc);
            ark   += int'(a_ark);
            key   += int'(a_key);
            bsy   += int'(a_busy);
            extra += int'(a_state_load);
            rdy   += int'(a_in_ready);
            step();
            lat++;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_out_ready = 0; b_in_valid = 0; b_out_ready = 0;
        #1 rst = 1'b0;
        #3;
        checks++;
        if ({a_sb, a_sr, a_mc, a_ark, a_key, a_state_load, a_out_valid, a_busy, a_in_ready}
            !== 9'b0) begin
            $display("FAIL reset_outputs: got %b want 000000000",
                     {a_sb, a_sr, a_mc, a_ark, a_key, a_state_load, a_out_valid, a_busy,
                      a_in_ready});
        end else passed++;
        checks++;
        if (a_round !== 4'd0) $display("FAIL reset_round: got %0d want 0", a_round);
        else passed++;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
            $display("FAIL reset_release_ready: got a=%b b=%b want 1 1", a_in_ready, b_in_ready);
        else passed++;
    endtask

    task automatic test_single_block();
        int sl0, lat, sb, sr, mc, ark, key, bsy, extra, rdy;
        run_a(sl0, lat, sb, sr, mc, ark, key, bsy, extra, rdy);
        checks++;
        if (sl0 !== 1) $display("FAIL blk_state_load: got %0d want 1", sl0); else passed++;
        checks++;
        if (lat !== 40) $display("FAIL blk_latency: got %0d want 40", lat); else passed++;
        checks++;
        if (sb !== 10 || sr !== 10) $display("FAIL blk_sb_sr: got %0d/%0d want 10/10", sb, sr);
        else passed++;
        checks++;
        if (mc !== 9) $display("FAIL blk_mc: got %0d want 9", mc); else passed++;
        checks++;
        if (ark !== 11) $display("FAIL blk_ark: got %0d want 11", ark); else passed++;
        checks++;
        if (key !== 10) $display("FAIL blk_key_step: got %0d want 10", key); else passed++;
        checks++;
        if (bsy !== 40) $display("FAIL blk_busy: got %0d want 40", bsy); else passed++;
        checks++;
        if (extra !== 0 || rdy !== 0)
            $display("FAIL blk_ignore_in_valid: got load=%0d ready=%0d want 0 0", extra, rdy);
        else passed++;
    endtask

    task automatic test_done_hold();
        int bad = 0;
        a_out_ready = 1'b0;
        repeat (20) begin
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_busy !== 1'b0 ||
                {a_sb, a_sr, a_mc, a_ark, a_key} !== 5'b0 || a_round !== 4'd10) bad++;
            step();
        end
        checks++;
        if (bad !== 0) $display("FAIL done_hold: got %0d bad cycles want 0", bad); else passed++;
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b1) $display("FAIL done_take_cycle: got %b want 1", a_out_valid);
        else passed++;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
            $display("FAIL done_to_idle: got valid=%b ready=%b want 0 1", a_out_valid, a_in_ready);
        else passed++;
        repeat (3) step();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0)
            $display("FAIL idle_out_ready: got valid=%b ready=%b busy=%b want 0 1 0",
                     a_out_valid, a_in_ready, a_busy);
        else passed++;
        a_out_ready = 1'b0;
    endtask

    task automatic test_mc_lat3();
        int lat = 0, runs = 0, run = 0, bad_run = 0, mc_r10 = 0, start_round = 0;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        while (!b_out_valid && lat < 300) begin
            if (b_mc) begin
                run++;
                if (run == 1) start_round = int'(b_round);
                if (b_round == 4'd10) mc_r10++;
            end else if (run != 0) begin
                runs++;
                if (run != 3 || start_round != runs) bad_run++;
                run = 0;
            end
            step();
            lat++;
        end
        checks++;
        if (lat !== 58) $display("FAIL mc3_latency: got %0d want 58", lat); else passed++;
        checks++;
        if (runs !== 9) $display("FAIL mc3_runs: got %0d want 9", runs); else passed++;
        checks++;
        if (bad_run !== 0 || mc_r10 !== 0)
            $display("FAIL mc3_run_shape: got bad=%0d r10=%0d want 0 0", bad_run, mc_r10);
        else passed++;
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        checks++;
        if (b_in_ready !== 1'b1) $display("FAIL mc3_idle: got %b want 1", b_in_ready);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int n = 0;
        int sl0, lat, sb, sr, mc, ark, key, bsy, extra, rdy;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        while (!(a_mc && a_round == 4'd5) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) $display("FAIL abort_reach_mix5: got timeout want mix in round 5");
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if ({a_sb, a_sr, a_mc, a_ark, a_key, a_state_load, a_out_valid, a_busy, a_in_ready}
            !== 9'b0 || a_round !== 4'd0)
            $display("FAIL abort_outputs: got %b round=%0d want 0 round=0",
                     {a_sb, a_sr, a_mc, a_ark, a_key, a_state_load, a_out_valid, a_busy,
                      a_in_ready}, a_round);
        else passed++;
        step();
        step();
        rst = 1'b1;
        #1;
        run_a(sl0, lat, sb, sr, mc, ark, key, bsy, extra, rdy);
        checks++;
        if (lat !== 40) $display("FAIL abort_latency: got %0d want 40", lat); else passed++;
        checks++;
        if (sb !== 10 || sr !== 10 || mc !== 9 || ark !== 11 || key !== 10)
            $display("FAIL abort_counts: got sb%0d sr%0d mc%0d ark%0d key%0d want 10 10 9 11 10",
                     sb, sr, mc, ark, key);
        else passed++;
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int bad_busy = 0, n = 0;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 140; cyc++) begin
            if (a_state_load) begin
                acc.push_back(cyc);
                if (a_busy) bad_busy++;
            end
            step();
        end
        a_in_valid = 1'b0;
        checks++;
        if (acc.size() !== 4) $display("FAIL b2b_accepts: got %0d want 4", acc.size());
        else passed++;
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] !== 42)
                $display("FAIL b2b_spacing: got %0d want 42", acc[i] - acc[i-1]);
            else passed++;
        end
        checks++;
        if (bad_busy !== 0) $display("FAIL b2b_busy_accept: got %0d want 0", bad_busy);
        else passed++;
        while (!a_in_ready && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (a_in_ready !== 1'b1) $display("FAIL b2b_drain: got %b want 1", a_in_ready);
        else passed++;
        a_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_done_hold();
        test_mc_lat3();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
